// File: rtl/karatsuba_pkg.sv
// Shared types and elaboration checks for the iterative Karatsuba multiplier.
package karatsuba_pkg;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        LO   = 5'b00010,
        HI   = 5'b00100,
        MID  = 5'b01000,
        OUT  = 5'b10000
    } state_e;

    function automatic bit karatsuba_w_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/karatsuba_half_mult.sv
// Combinational (H+1)x(H+1) unsigned multiplier; the single multiplier shared by all Karatsuba phases.
module karatsuba_half_mult #(
    parameter int H = 16
) (
    input  logic [H:0]     a_i,
    input  logic [H:0]     b_i,
    output logic [2*H+1:0] p_o
);

    assign p_o = {{(H+1){1'b0}}, a_i} * {{(H+1){1'b0}}, b_i};

endmodule

// File: rtl/iterative_karatsuba_n.sv
// Sequential W-bit Karatsuba multiplier, one shared half-width multiplier over LO/HI/MID phases.
// Define KARATSUBA_SIGNED_EN to add the in_signed port for two's-complement operands.
module iterative_karatsuba_n
    import karatsuba_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
`ifdef KARATSUBA_SIGNED_EN
    input  logic           in_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    localparam int H = W / 2;

    if (!karatsuba_w_ok(W)) begin : g_w_check
        $error("iterative_karatsuba_n: W must be even and >= 4");
    end

    state_e           state_q, state_d;
    logic [H-1:0]     a_h_q, a_l_q, b_h_q, b_l_q;
    logic [2*H-1:0]   p_lo_q, p_hi_q;
    logic [2*W-1:0]   out_p_q, out_p_d;
    logic             neg_q, neg_d;
    logic             accept;
    logic [W-1:0]     a_mag, b_mag;
    logic [H:0]       mul_x, mul_y;
    logic [2*H+1:0]   mul_p;
    logic [2*H+1:0]   mid;
    logic [2*W-1:0]   mag;

    // Valid/ready: a transfer happens on a cycle where valid and ready are both high at the
    // rising edge; a producer holds valid and data until that edge, and the result stays
    // valid and stable in OUT until the consumer takes it.
    assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_p     = out_p_q;

`ifdef KARATSUBA_SIGNED_EN
    logic a_neg, b_neg;
    assign a_neg = in_signed & in_a[W-1];
    assign b_neg = in_signed & in_b[W-1];
    assign a_mag = a_neg ? ((~in_a) + W'(1)) : in_a;
    assign b_mag = b_neg ? ((~in_b) + W'(1)) : in_b;
    assign neg_d = a_neg ^ b_neg;
`else
    assign a_mag = in_a;
    assign b_mag = in_b;
    assign neg_d = 1'b0;
`endif

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            LO: begin
                mul_x = {1'b0, a_l_q};
                mul_y = {1'b0, b_l_q};
            end
            HI: begin
                mul_x = {1'b0, a_h_q};
                mul_y = {1'b0, b_h_q};
            end
            MID: begin
                mul_x = {1'b0, a_h_q} + {1'b0, a_l_q};
                mul_y = {1'b0, b_h_q} + {1'b0, b_l_q};
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    karatsuba_half_mult #(.H(H)) u_half_mult (
        .a_i (mul_x),
        .b_i (mul_y),
        .p_o (mul_p)
    );

    // (a_h+a_l)(b_h+b_l) - a_h*b_h - a_l*b_l is the cross term and cannot go negative.
    assign mid     = mul_p - {2'b00, p_hi_q} - {2'b00, p_lo_q};
    assign mag     = {p_hi_q, p_lo_q} + ({{(2*W-2*H-2){1'b0}}, mid} << H);
    assign out_p_d = neg_q ? ((~mag) + (2*W)'(1)) : mag;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = MID;
            MID:     state_d = OUT;
            OUT:     if (out_ready) state_d = in_valid ? LO : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_h_q   <= '0;
            a_l_q   <= '0;
            b_h_q   <= '0;
            b_l_q   <= '0;
            p_lo_q  <= '0;
            p_hi_q  <= '0;
            out_p_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_h_q <= a_mag[W-1:H];
                a_l_q <= a_mag[H-1:0];
                b_h_q <= b_mag[W-1:H];
                b_l_q <= b_mag[H-1:0];
                neg_q <= neg_d;
            end
            if (state_q == LO)  p_lo_q  <= mul_p[2*H-1:0];
            if (state_q == HI)  p_hi_q  <= mul_p[2*H-1:0];
            if (state_q == MID) out_p_q <= out_p_d;
        end
    end

endmodule

// File: doc/iterative_karatsuba_n.md
Name: iterative_karatsuba_n

Overview:
Parametrised sequential Karatsuba multiplier. Computes the full 2W-bit product of two W-bit operands. Time-shares one (W/2+1)-bit multiplier over three cycles.
Successor to the fixed 32-bit iterative multiplier, adding:
- generic width
- valid/ready handshakes on input and output
- back-to-back operation
- optional signed mode
Sits between operand producers (ALU/MAC front-end) and result consumers in the arithmetic datapath.

Parameters:
- W, default 32: operand width. Must be even and >= 4; elaboration error otherwise.
- H, default W/2: half width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- in_a  input  W  multiplicand
- in_b  input  W  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_p  output  2W  product
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, out_valid=0, out_p=0, all operand/partial registers 0. Reset mid-operation discards the operation; no result is ever produced for it.
- States and transitions: IDLE -> LO -> HI -> MID -> OUT.
- Input handshake:
  - in_ready = (state==IDLE) | (state==OUT & out_ready).
  - Accept on in_valid & in_ready: latch a_h/a_l/b_h/b_l, go to LO.
- LO: P_lo <= a_l*b_l (2H bits); go to HI.
- HI: P_hi <= a_h*b_h (2H bits); go to MID.
- MID:
  - Form s_a=a_h+a_l and s_b=b_h+b_l (H+1 bits each, no truncation).
  - m = s_a*s_b (2H+2 bits), computed on the same shared multiplier.
  - mid = m - P_hi - P_lo, computed at 2H+2 bits; always >= 0.
  - out_p <= {P_hi,P_lo} + (mid << H), computed at 2W bits, no overflow possible.
  - Go to OUT.
- Multiplier sharing: the shared multiplier operand mux is selected by state. Only one multiplier instance is allowed.
- OUT:
  - out_valid=1. out_p is held stable while out_ready=0, for unbounded backpressure.
  - On out_ready=1 with in_valid=1: new operands are accepted in the same cycle, go to LO (back-to-back).
  - On out_ready=1 with in_valid=0: go to IDLE, out_valid falls next cycle.
- Timing:
  - Latency is 3 cycles: an accept at edge E0 gives out_valid=1 after edge E3.
  - Throughput is one result per 4 cycles when the consumer is always ready.
- Input sampling: in_a/in_b are ignored except at accept. Changes during LO/HI/MID have no effect.
- out_valid is never deasserted without a handshake, except by reset.
- No enable port; stalling is only via the handshakes.

Optional Feature:
- Macro: KARATSUBA_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), sampled at accept.
  - When in_signed=1, operands are two's complement.
  - The core multiplies magnitudes |a| and |b|, each W bits unsigned; |-2^(W-1)| = 2^(W-1) fits.
  - The final 2W-bit result is negated in MID if sign(a) XOR sign(b).
  - Latency is unchanged.
- Undefined: no in_signed port; all operands are unsigned.

Decomposition:
- Package karatsuba_pkg holds:
  - state typedef (IDLE, LO, HI, MID, OUT; one-hot encoding)
  - localparam function checking W validity
- Sub-module karatsuba_half_mult: purely combinational (H+1)x(H+1) -> 2H+2 unsigned multiplier, parameter H. Exactly one instance, in the top.
- FSM, operand mux, partial-product registers and combine adder stay in the top module.

Test Plan:
- W=32, in_a=in_b=0xFFFFFFFF, out_ready=1 -> out_p=0xFFFFFFFE00000001, out_valid rises exactly 3 cycles after accept.
- W=32, in_a=0x00010000, in_b=0x00010000 -> out_p=0x0000000100000000. Also in_a=0, in_b=0xDEADBEEF -> out_p=0.
- W=16, in_a=0xFFFF, in_b=0x0002 -> out_p=0x0001FFFE.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_p stable, in_ready=0. Then out_ready=1 with in_valid=1 and new operands 3 x 7 -> next result 21 appears 3 cycles later, with no IDLE cycle between.
- Reset: rst=0 during HI -> out_valid=0 and busy=0 immediately, out_p=0. After release, no stale result and next operation correct.
- KARATSUBA_SIGNED_EN, W=32, in_signed=1:
  - -3 x 5 -> 0xFFFFFFFFFFFFFFF1.
  - 0x80000000 x 0x80000000 -> 0x4000000000000000.
  - in_signed=0 on the same operands -> 0x4000000000000000.
